buzzer_arbiter: RTL and testbench

Shares the board's single piezo buzzer between three note requesters: alarm, key-click and music player. Fixed-priority arbiter with an integrated square-wave tone generator and beat timer. Each requester presents a half-period and a duration in beats and holds a request until it is served. Sits between the tune and alert sources and the `o_buzzer` pin.

---
 rtl/buzzer_arbiter.sv | 215 +++++++++++++++++++++
 tb/tb_buzzer_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_arbiter.sv
// buzzer_arbiter: fixed-priority owner of the single piezo buzzer.
// Three requesters (bit 0 = highest priority) each present a half-period and
// a length in beats; the granted note is played as a square wave, timed by a
// beat counter, and followed by a silent gap before the next arbitration.
// Optional feature macro: BUZZER_PREEMPT_EN (higher-priority request aborts
// the note in progress and takes the buzzer on the same edge).
module buzzer_arbiter #(
    parameter int unsigned BEAT_CYCLES = 12000000,
    parameter int unsigned GAP_CYCLES  = 1200000
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [2:0]  i_req,
    input  logic [47:0] i_half_period,
    input  logic [23:0] i_beats,
    output logic [2:0]  o_grant,
    output logic [2:0]  o_done,
    output logic [2:0]  o_abort,
    output logic        o_buzzer
);

    localparam logic [31:0] BEAT_LAST = 32'(BEAT_CYCLES - 1);
    localparam logic [31:0] GAP_LAST  = (GAP_CYCLES == 0) ? 32'd0 : 32'(GAP_CYCLES - 1);
    localparam bit          GAP_SKIP  = (GAP_CYCLES == 0);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [2:0]  grant_q, grant_d;
    logic [2:0]  done_q, done_d;
    logic [2:0]  abort_q, abort_d;
    logic        buzzer_q, buzzer_d;
    logic [15:0] hp_q, hp_d;
    logic [7:0]  beats_left_q, beats_left_d;
    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic [31:0] beat_cnt_q, beat_cnt_d;
    logic [31:0] gap_cnt_q, gap_cnt_d;
    // Low for the first edge after reset release so arbitration starts one
    // edge later, giving the rest of the system a clean cycle out of reset.
    logic        run_q, run_d;

    // Per-requester views of the packed data buses.
    logic [15:0] req_hp    [3];
    logic [7:0]  req_beats [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_unpack
        assign req_hp[gi]    = i_half_period[16*gi +: 16];
        assign req_beats[gi] = i_beats[8*gi +: 8];
    end

    // Lowest set request bit wins (x & -x isolates it).
    logic [2:0]  pick_oh;
    logic [15:0] sel_hp;
    logic [7:0]  sel_beats;
    logic [7:0]  sel_beats_norm;
    logic        cancel;

    assign pick_oh        = i_req & (~i_req + 3'd1);
    assign sel_beats_norm = (sel_beats == 8'd0) ? 8'd1 : sel_beats;
    assign cancel         = ~|(i_req & grant_q);

`ifdef BUZZER_PREEMPT_EN
    // Any request strictly below the current grant index outranks it.
    logic preempt;
    assign preempt = |(i_req & (grant_q - 3'd1));
`endif

    // Mux the winning requester's note data out of the packed buses.
    always_comb begin
        sel_hp    = '0;
        sel_beats = '0;
        for (int i = 0; i < 3; i++) begin
            if (pick_oh[i]) begin
                sel_hp    = sel_hp | req_hp[i];
                sel_beats = sel_beats | req_beats[i];
            end
        end
    end

    // Next-state, counter and output computation for the IDLE/PLAY/GAP FSM.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        done_d       = 3'b000;
        abort_d      = 3'b000;
        buzzer_d     = buzzer_q;
        hp_d         = hp_q;
        beats_left_d = beats_left_q;
        tone_cnt_d   = tone_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        run_d        = 1'b1;

        case (state_q)
            ST_IDLE: begin
                buzzer_d = 1'b0;
                if (run_q && (|i_req)) begin
                    state_d      = ST_PLAY;
                    grant_d      = pick_oh;
                    hp_d         = sel_hp;
                    beats_left_d = sel_beats_norm;
                    tone_cnt_d   = '0;
                    beat_cnt_d   = '0;
                end
            end

            ST_PLAY: begin
                // Tone: toggle every hp+1 cycles; hp=0 is a rest.
                if (hp_q == 16'd0) begin
                    tone_cnt_d = '0;
                    buzzer_d   = 1'b0;
                end else if (tone_cnt_q == hp_q) begin
                    tone_cnt_d = '0;
                    buzzer_d   = ~buzzer_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 16'd1;
                end

                // Duration: one beat per BEAT_CYCLES cycles.
                if (beat_cnt_q == BEAT_LAST) begin
                    beat_cnt_d   = '0;
                    beats_left_d = beats_left_q - 8'd1;
                end else begin
                    beat_cnt_d = beat_cnt_q + 32'd1;
                end

                if ((beat_cnt_q == BEAT_LAST) && (beats_left_q == 8'd1)) begin
                    // Completion takes precedence over a simultaneous cancel.
                    done_d     = grant_q;
                    grant_d    = 3'b000;
                    buzzer_d   = 1'b0;
                    tone_cnt_d = '0;
                    beat_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = GAP_SKIP ? ST_IDLE : ST_GAP;
                end else if (cancel) begin
                    grant_d    = 3'b000;
                    buzzer_d   = 1'b0;
                    tone_cnt_d = '0;
                    beat_cnt_d = '0;
                    gap_cnt_d  = '0;
                    state_d    = GAP_SKIP ? ST_IDLE : ST_GAP;
                end
`ifdef BUZZER_PREEMPT_EN
                else if (preempt) begin
                    // Hand the buzzer straight to the new winner; the aborted
                    // request stays pending and replays from the start later.
                    abort_d      = grant_q;
                    grant_d      = pick_oh;
                    hp_d         = sel_hp;
                    beats_left_d = sel_beats_norm;
                    tone_cnt_d   = '0;
                    beat_cnt_d   = '0;
                    buzzer_d     = 1'b0;
                end
`endif
            end

            ST_GAP: begin
                buzzer_d = 1'b0;
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = '0;
                    state_d   = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + 32'd1;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                grant_d  = 3'b000;
                buzzer_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset asserts asynchronously.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= 3'b000;
            done_q       <= 3'b000;
            abort_q      <= 3'b000;
            buzzer_q     <= 1'b0;
            hp_q         <= '0;
            beats_left_q <= '0;
            tone_cnt_q   <= '0;
            beat_cnt_q   <= '0;
            gap_cnt_q    <= '0;
            run_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            done_q       <= done_d;
            abort_q      <= abort_d;
            buzzer_q     <= buzzer_d;
            hp_q         <= hp_d;
            beats_left_q <= beats_left_d;
            tone_cnt_q   <= tone_cnt_d;
            beat_cnt_q   <= beat_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            run_q        <= run_d;
        end
    end

    assign o_grant  = grant_q;
    assign o_done   = done_q;
    assign o_abort  = abort_q;
    assign o_buzzer = buzzer_q;

endmodule

// File: tb/tb_buzzer_arbiter.sv
// Scoreboard bench for buzzer_arbiter (BEAT_CYCLES=10, GAP_CYCLES=3).
// Stimulus pushes hand-computed output events (kind, value, cycle) into a
// queue; the monitor reports every output change/pulse and pops to compare.
module tb_buzzer_arbiter;

    localparam int BEAT = 10;
    localparam int GAP  = 3;

    localparam int K_GRANT = 0;
    localparam int K_DONE  = 1;
    localparam int K_ABORT = 2;
    localparam int K_BUZZ  = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [2:0]  req = 3'b000;
    logic [47:0] hp_bus = '0;
    logic [23:0] beats_bus = '0;
    logic [2:0]  grant;
    logic [2:0]  done;
    logic [2:0]  abort;
    logic        buzzer;

    buzzer_arbiter #(
        .BEAT_CYCLES(BEAT),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk          (clk),
        .i_rst_n      (rst_n),
        .i_req        (req),
        .i_half_period(hp_bus),
        .i_beats      (beats_bus),
        .o_grant      (grant),
        .o_done       (done),
        .o_abort      (abort),
        .o_buzzer     (buzzer)
    );

    always #5 clk = ~clk;

    // Count of rising edges so far; read on the falling edge.
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int         kind;
        logic [2:0] val;
        int         at;
    } ev_t;

    ev_t exp_q[$];

    function automatic string kname(input int k);
        case (k)
            K_GRANT: return "grant";
            K_DONE:  return "done";
            K_ABORT: return "abort";
            default: return "buzzer";
        endcase
    endfunction

    task automatic push(input int kind, input logic [2:0] val, input int at);
        ev_t e;
        e.kind = kind;
        e.val  = val;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int kind, input logic [2:0] val);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL %s: got %b at cycle %0d, required no event", kname(kind), val, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || e.val !== val || e.at != cyc) begin
                errors++;
                $display("FAIL %s: got %s=%b at cycle %0d, required %s=%b at cycle %0d",
                         kname(kind), kname(kind), val, cyc, kname(e.kind), e.val, e.at);
            end else begin
                $display("ok   %s=%b at cycle %0d", kname(kind), val, cyc);
            end
        end
    endtask

    // Monitor: report output changes in a fixed order each cycle.
    logic [2:0] prev_grant = 3'b000;
    logic       prev_buz = 1'b0;
    always @(negedge clk) begin
        if (grant !== prev_grant) observe(K_GRANT, grant);
        if (done !== 3'b000)      observe(K_DONE, done);
        if (abort !== 3'b000)     observe(K_ABORT, abort);
        if (buzzer !== prev_buz)  observe(K_BUZZ, {2'b00, buzzer});
        prev_grant = grant;
        prev_buz   = buzzer;
    end

    task automatic check_zero(input string name);
        checks++;
        if ({grant, done, abort, buzzer} !== 10'b0) begin
            errors++;
            $display("FAIL %s: got grant=%b done=%b abort=%b buzzer=%b, required all 0",
                     name, grant, done, abort, buzzer);
        end else begin
            $display("ok   %s: outputs all 0 at cycle %0d", name, cyc);
        end
    endtask

    task automatic goto(input int n);
        if (cyc > n) begin
            $display("FAIL sequencing: at cycle %0d, required cycle %0d", cyc, n);
            $fatal(1, "sequencing");
        end
        while (cyc < n) @(negedge clk);
    endtask

    task automatic set_req(input int k, input logic [15:0] hp, input logic [7:0] b);
        hp_bus[16*k +: 16] = hp;
        beats_bus[8*k +: 8] = b;
        req[k] = 1'b1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int g, h, p, r, k, q;
        ev_t e;

        repeat (3) @(negedge clk);
        check_zero("reset_state");
        #2 rst_n = 1'b1;
        goto(cyc + 3);

        // Single note: req0 hp=4 beats=2 -> period 10, 20 PLAY cycles.
        g = cyc + 1;
        set_req(0, 16'd4, 8'd2);
        push(K_GRANT, 3'b001, g);
        push(K_BUZZ, 3'd1, g + 5);
        push(K_BUZZ, 3'd0, g + 10);
        push(K_BUZZ, 3'd1, g + 15);
        push(K_GRANT, 3'b000, g + 20);
        push(K_DONE, 3'b001, g + 20);
        push(K_BUZZ, 3'd0, g + 20);
        goto(g + 20);
        req[0] = 1'b0;
        goto(g + 26);

        // Priority: req0 and req2 together; req2 granted 4 cycles after done[0].
        g = cyc + 1;
        set_req(0, 16'd2, 8'd1);
        set_req(2, 16'd3, 8'd1);
        h = g + 14;
        push(K_GRANT, 3'b001, g);
        push(K_BUZZ, 3'd1, g + 3);
        push(K_BUZZ, 3'd0, g + 6);
        push(K_BUZZ, 3'd1, g + 9);
        push(K_GRANT, 3'b000, g + 10);
        push(K_DONE, 3'b001, g + 10);
        push(K_BUZZ, 3'd0, g + 10);
        push(K_GRANT, 3'b100, h);
        push(K_BUZZ, 3'd1, h + 4);
        push(K_BUZZ, 3'd0, h + 8);
        push(K_GRANT, 3'b000, h + 10);
        push(K_DONE, 3'b100, h + 10);
        goto(g + 10);
        req[0] = 1'b0;
        goto(h + 10);
        req[2] = 1'b0;
        goto(h + 16);

        // Rest with zero beats: buzzer silent, done after one beat.
        g = cyc + 1;
        set_req(1, 16'd0, 8'd0);
        push(K_GRANT, 3'b010, g);
        push(K_GRANT, 3'b000, g + 10);
        push(K_DONE, 3'b010, g + 10);
        goto(g + 10);
        req[1] = 1'b0;
        goto(g + 16);

        // Preemption attempt: req2 (beats=3) playing, req0 raised 15 cycles in.
        g = cyc + 1;
        set_req(2, 16'd4, 8'd3);
        push(K_GRANT, 3'b100, g);
        push(K_BUZZ, 3'd1, g + 5);
        push(K_BUZZ, 3'd0, g + 10);
        push(K_BUZZ, 3'd1, g + 15);
`ifdef BUZZER_PREEMPT_EN
        p = g + 16;
        r = p + 14;
        push(K_GRANT, 3'b001, p);
        push(K_ABORT, 3'b100, p);
        push(K_BUZZ, 3'd0, p);
        push(K_BUZZ, 3'd1, p + 3);
        push(K_BUZZ, 3'd0, p + 6);
        push(K_BUZZ, 3'd1, p + 9);
        push(K_GRANT, 3'b000, p + 10);
        push(K_DONE, 3'b001, p + 10);
        push(K_BUZZ, 3'd0, p + 10);
        push(K_GRANT, 3'b100, r);
        push(K_BUZZ, 3'd1, r + 5);
        push(K_BUZZ, 3'd0, r + 10);
        push(K_BUZZ, 3'd1, r + 15);
        push(K_BUZZ, 3'd0, r + 20);
        push(K_BUZZ, 3'd1, r + 25);
        push(K_GRANT, 3'b000, r + 30);
        push(K_DONE, 3'b100, r + 30);
        push(K_BUZZ, 3'd0, r + 30);
        goto(g + 15);
        set_req(0, 16'd2, 8'd1);
        goto(p + 10);
        req[0] = 1'b0;
        goto(r + 30);
        req[2] = 1'b0;
        goto(r + 36);
`else
        p = g + 34;
        push(K_BUZZ, 3'd0, g + 20);
        push(K_BUZZ, 3'd1, g + 25);
        push(K_GRANT, 3'b000, g + 30);
        push(K_DONE, 3'b100, g + 30);
        push(K_BUZZ, 3'd0, g + 30);
        push(K_GRANT, 3'b001, p);
        push(K_BUZZ, 3'd1, p + 3);
        push(K_BUZZ, 3'd0, p + 6);
        push(K_BUZZ, 3'd1, p + 9);
        push(K_GRANT, 3'b000, p + 10);
        push(K_DONE, 3'b001, p + 10);
        push(K_BUZZ, 3'd0, p + 10);
        goto(g + 15);
        set_req(0, 16'd2, 8'd1);
        goto(g + 30);
        req[2] = 1'b0;
        goto(p + 10);
        req[0] = 1'b0;
        goto(p + 16);
`endif

        // Cancel: req1 drops 5 cycles in; no done, 3-cycle gap before req0.
        g = cyc + 1;
        set_req(1, 16'd4, 8'd2);
        k = g + 10;
        push(K_GRANT, 3'b010, g);
        push(K_BUZZ, 3'd1, g + 5);
        push(K_GRANT, 3'b000, g + 6);
        push(K_BUZZ, 3'd0, g + 6);
        push(K_GRANT, 3'b001, k);
        push(K_BUZZ, 3'd1, k + 5);
        push(K_GRANT, 3'b000, k + 10);
        push(K_DONE, 3'b001, k + 10);
        push(K_BUZZ, 3'd0, k + 10);
        goto(g + 5);
        req[1] = 1'b0;
        goto(g + 6);
        set_req(0, 16'd4, 8'd1);
        goto(k + 10);
        req[0] = 1'b0;
        goto(k + 16);

        // Reset mid-PLAY: outputs clear at once, pending req0 regranted
        // on the second edge after release.
        g = cyc + 1;
        set_req(0, 16'd4, 8'd2);
        q = g + 11;
        push(K_GRANT, 3'b001, g);
        push(K_BUZZ, 3'd1, g + 5);
        push(K_GRANT, 3'b000, g + 8);
        push(K_BUZZ, 3'd0, g + 8);
        push(K_GRANT, 3'b001, q);
        push(K_BUZZ, 3'd1, q + 5);
        push(K_BUZZ, 3'd0, q + 10);
        push(K_BUZZ, 3'd1, q + 15);
        push(K_GRANT, 3'b000, q + 20);
        push(K_DONE, 3'b001, q + 20);
        push(K_BUZZ, 3'd0, q + 20);
        goto(g + 7);
        #2 rst_n = 1'b0;
        #1 check_zero("async_reset");
        goto(g + 9);
        #2 rst_n = 1'b1;
        goto(q + 20);
        req[0] = 1'b0;
        goto(q + 26);
        check_zero("final_idle");

        // Anything still queued was never produced by the DUT.
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL missing %s: got no event, required %s=%b at cycle %0d",
                     kname(e.kind), kname(e.kind), e.val, e.at);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
